// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter and related
// schedulers: FSM encoding, width helpers and the round-robin search.
package fifo_arb_pkg;

   // Upper bound on requesters the generic round-robin search supports.
   localparam int RR_MAX_REQ = 32;
   localparam int RR_IDX_W   = $clog2(RR_MAX_REQ);

   // Legacy-compatible state encodings; the enum below reuses them.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      BURST = S_BURST,
      FLUSH = S_FLUSH
   } state_t;

   // Grant index width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Beat counter width: must be able to hold MAX_BURST itself.
   function automatic int beat_width(input int max_burst);
      return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
   endfunction

   // First set bit of valid[n-1:0] searching upward from last+1, wrapping
   // at n (not at a power of two). Returns last when nothing is valid.
   // The loop bound is a constant so the search unrolls in synthesis; the
   // scan runs from the far end so the nearest candidate wins.
   function automatic int rr_next(input logic [RR_MAX_REQ-1:0] valid,
                                  input int last, input int n);
      int idx;
      int res;
      res = last;
      for (int k = RR_MAX_REQ; k >= 1; k--) begin
         if (k <= n) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (valid[idx[RR_IDX_W-1:0]]) res = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: picks the first asserted request
// after the last winner, wrapping modulo N_REQ. Shared with read-side
// schedulers, so it holds no state of its own.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last,
   output logic [ID_W-1:0]  grant,
   output logic             any_valid
);

   logic [RR_MAX_REQ-1:0] req_ext;
   int                    pick;

   // Widen to the search function's fixed width; unused upper bits are zero.
   always_comb begin
      req_ext            = '0;
      req_ext[N_REQ-1:0] = req;
   end

   // Rotating search starting just past the previous winner.
   always_comb begin
      pick      = rr_next(req_ext, int'(last), N_REQ);
      grant     = pick[ID_W-1:0];
      any_valid = |req;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the fifo write port among N_REQ producers. Round-robin grants,
// each held for up to MAX_BURST words, with one bubble cycle between
// bursts. Clear requests are queued and only issued from IDLE so a clear
// never cuts a burst in half.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WORD_SIZE = 8,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WORD_SIZE-1:0] req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       flush_req,
   output logic                       flush_done,
   input  logic                       fifo_full,
   output logic                       fifo_we,
   output logic [WORD_SIZE-1:0]       fifo_wdata,
   output logic                       fifo_clr,
   output logic [ID_W-1:0]            grant_id,
   output logic                       busy
);

   localparam int BEAT_W = beat_width(MAX_BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

   state_t            state;
   logic [ID_W-1:0]   last_grant;
   logic [BEAT_W-1:0] beat;
   logic              flush_pend;

   logic [ID_W-1:0]      pick;
   logic                 any_valid;
   logic [WORD_SIZE-1:0] sel_data;
   logic                 sel_valid;
   logic                 in_burst;
   logic                 burst_end;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req       (req_valid),
      .last      (last_grant),
      .grant     (pick),
      .any_valid (any_valid)
   );

   // Select the granted producer's word and valid. Also drives fifo_wdata
   // outside BURST so the bus follows grant_id instead of floating.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_data  = req_data[i*WORD_SIZE +: WORD_SIZE];
            sel_valid = req_valid[i];
         end
      end
   end

   // rst gates the write strobes so a word offered in the reset cycle is
   // dropped even though the state register still reads BURST.
   assign in_burst   = (state == BURST) & ~rst;
   assign fifo_we    = in_burst & sel_valid & ~fifo_full;
   assign fifo_wdata = sel_data;
   assign fifo_clr   = (state == FLUSH) & ~rst;
   assign busy       = (state != IDLE);

   // A burst closes on its last allowed transfer or as soon as the owner
   // stops offering data; a full stall alone never closes it.
   assign burst_end  = ~sel_valid | (fifo_we & (beat == LAST_BEAT));

   // Per-requester accept: only the owner sees ready, and only when the
   // fifo can take the word.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = in_burst & ~fifo_full & (grant_id == ID_W'(gi));
   end

   // Clear requests latch until the FSM reaches FLUSH; a new request in
   // the cycle the latch is consumed stays pending for another clear.
   always_ff @(posedge clk) begin
      if (rst)
         flush_pend <= 1'b0;
      else if (flush_req)
         flush_pend <= 1'b1;
      else if (state == IDLE && flush_pend)
         flush_pend <= 1'b0;
   end

   // Completion pulse trails the single FLUSH cycle by one clock.
   always_ff @(posedge clk) begin
      if (rst)
         flush_done <= 1'b0;
      else
         flush_done <= (state == FLUSH);
   end

   // Main sequencer: IDLE arbitrates (clear first), BURST counts beats,
   // FLUSH lasts exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= ID_W'(N_REQ - 1);
         beat       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_pend) begin
                  state <= FLUSH;
               end else if (any_valid) begin
                  grant_id <= pick;
                  beat     <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (fifo_we)
                  beat <= beat + BEAT_W'(1);
               if (burst_end) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
               end
            end
            FLUSH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter. Producers are modelled as word
// queues; every word offered is also pushed into a per-producer
// scoreboard. A negedge monitor keeps a transaction-level model of the
// arbitration rules and pops the scoreboard on every fifo write.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;
   localparam int IW = 2;

   localparam int M_IDLE  = 0;
   localparam int M_BURST = 1;
   localparam int M_FLUSH = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           flush_req;
   logic           flush_done;
   logic           fifo_full;
   logic           fifo_we;
   logic [W-1:0]   fifo_wdata;
   logic           fifo_clr;
   logic [IW-1:0]  grant_id;
   logic           busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .WORD_SIZE (W),
      .MAX_BURST (MB),
      .ID_W      (IW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .fifo_full  (fifo_full),
      .fifo_we    (fifo_we),
      .fifo_wdata (fifo_wdata),
      .fifo_clr   (fifo_clr),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   int ncmp = 0;
   int nerr = 0;

   logic [W-1:0] src[N][$];
   logic [W-1:0] exp_q[N][$];
   logic [N-1:0] acc = '0;

   int   m_st    = M_IDLE;
   int   m_g     = 0;
   int   m_last  = N - 1;
   int   m_beats = 0;
   bit   m_pend  = 1'b0;
   bit   m_done  = 1'b0;
   bit   mv      = 1'b0;
   bit   nxt_pend;
   logic e_we;
   logic [N-1:0] e_rdy;
   logic [W-1:0] e_word;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
      ncmp++;
      if (act !== e) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, e, $time);
      end
   endtask

   // Round-robin rule: first valid index after last, wrapping modulo N.
   function automatic int rr(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return last;
   endfunction

   // Monitor and reference model, evaluated mid-cycle.
   always @(negedge clk) begin
      acc = req_valid & req_ready;
      if (mv) begin
         e_we  = !rst && m_st == M_BURST && req_valid[m_g] && !fifo_full;
         e_rdy = '0;
         if (!rst && m_st == M_BURST && !fifo_full) e_rdy[m_g] = 1'b1;
         chk("busy",       busy,       m_st != M_IDLE);
         chk("fifo_clr",   fifo_clr,   !rst && m_st == M_FLUSH);
         chk("grant_id",   grant_id,   m_g);
         chk("fifo_we",    fifo_we,    e_we);
         chk("req_ready",  req_ready,  e_rdy);
         chk("flush_done", flush_done, m_done);
         if (fifo_we === 1'b1 && !$isunknown(grant_id)) begin
            if (exp_q[grant_id].size() == 0) begin
               ncmp++;
               nerr++;
               $display("FAIL fifo_wdata: wrote %0h for requester %0d with no word outstanding",
                        fifo_wdata, grant_id);
            end else begin
               e_word = exp_q[grant_id].pop_front();
               chk("fifo_wdata", fifo_wdata, e_word);
            end
         end
      end
      if (rst) begin
         mv      = 1'b1;
         m_st    = M_IDLE;
         m_g     = 0;
         m_last  = N - 1;
         m_beats = 0;
         m_pend  = 1'b0;
         m_done  = 1'b0;
      end else if (mv) begin
         m_done   = (m_st == M_FLUSH);
         nxt_pend = flush_req || (m_pend && m_st != M_IDLE);
         case (m_st)
            M_IDLE: begin
               if (m_pend) m_st = M_FLUSH;
               else if (|req_valid) begin
                  m_g     = rr(req_valid, m_last);
                  m_beats = 0;
                  m_st    = M_BURST;
               end
            end
            M_BURST: begin
               if (e_we) m_beats++;
               if (!req_valid[m_g] || m_beats == MB) begin
                  m_last = m_g;
                  m_st   = M_IDLE;
               end
            end
            default: m_st = M_IDLE;
         endcase
         m_pend = nxt_pend;
      end
   end

   // One clock of stimulus: retire accepted words, refill producers, and
   // randomize pauses, fifo_full, clear pulses and resets.
   task automatic step(input logic [N-1:0] gen, input int pause_pct, input int full_pct,
                       input int flush_pct, input int rst_pct);
      logic [W-1:0] w;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && src[i].size() > 0) w = src[i].pop_front();
         if (gen[i] && src[i].size() < 4) begin
            w = W'($urandom);
            src[i].push_back(w);
            exp_q[i].push_back(w);
         end
         req_valid[i] = (src[i].size() > 0) && ($urandom_range(99) >= pause_pct);
         req_data[i*W +: W] = (src[i].size() > 0) ? src[i][0] : W'($urandom);
      end
      fifo_full = ($urandom_range(99) < full_pct);
      flush_req = ($urandom_range(99) < flush_pct);
      rst       = ($urandom_range(99) < rst_pct);
   endtask

   initial begin
      int left;
      int sb_left;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      flush_req = 1'b0;
      fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // Lone producer 0 streaming: back-to-back bursts with one bubble.
      repeat (40) step(4'b0001, 0, 0, 0, 0);
      // All producers saturated: strict 0,1,2,3 rotation.
      repeat (80) step(4'b1111, 0, 0, 0, 0);
      // Mixed traffic: drops, full stalls, clears and resets.
      repeat (1500) step(4'b1111, 20, 20, 3, 1);
      // A few saturated cycles with clears to exercise clear-vs-burst.
      repeat (200) step(4'b1111, 0, 10, 5, 0);
      // Drain every producer with a bounded cycle budget.
      left = 0;
      for (int c = 0; c < 400; c++) begin
         left = 0;
         for (int i = 0; i < N; i++) left += src[i].size();
         if (left == 0) break;
         step('0, 0, 0, 0, 0);
      end
      @(negedge clk);
      #1;
      left    = 0;
      sb_left = 0;
      for (int i = 0; i < N; i++) begin
         left    += src[i].size();
         sb_left += exp_q[i].size();
      end
      chk("drain_src", left, 0);
      chk("drain_scoreboard", sb_left, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's fifo block among N_REQ producers.
- Uses round-robin arbitration with burst locking: a granted producer keeps the port for up to MAX_BURST words.
- Sequences FIFO clear requests (drives the fifo's fwft/clear input) so a clear never lands mid-burst.
- Sits directly in front of the fifo instance: drives we/wdata/fwft, observes full.

Parameters:
- N_REQ, 4: number of requesters (≥2).
- WORD_SIZE, 8: data word width; must match the fifo.
- MAX_BURST, 4: maximum words per grant (≥1).
- ID_W, $clog2(N_REQ): grant index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*WORD_SIZE  flattened words; requester i at [i*WORD_SIZE +: WORD_SIZE].
- req_ready  out  N_REQ  per-requester accept.
- flush_req  in  1  single-cycle clear request.
- flush_done  out  1  one-cycle pulse, clear completed.
- fifo_full  in  1  from fifo full.
- fifo_we  out  1  to fifo we.
- fifo_wdata  out  WORD_SIZE  to fifo wdata.
- fifo_clr  out  1  to fifo fwft (clear).
- grant_id  out  ID_W  current/last granted requester.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, BURST, FLUSH. Reset value is IDLE.
- Reset values: grant_id=0, last_grant=N_REQ-1 (so requester 0 wins first), beat=0, flush_pend=0, flush_done=0.
- Reset outputs: fifo_we=0, fifo_clr=0, req_ready=0.
- rst mid-operation aborts any burst or flush immediately. A word presented in the rst cycle is not written.
- flush_pend:
  - Set on flush_req in any state.
  - Cleared when FLUSH is entered.
  - flush_req and clear on the same cycle: remains set.
- IDLE:
  - If flush_pend, go to FLUSH. Flush has priority over arbitration.
  - Else if |req_valid, grant_id <= first valid index searching from last_grant+1 modulo N_REQ; beat <= 0; go to BURST.
  - Else stay in IDLE.
  - Grant latency is one cycle after req_valid is seen.
- BURST (g = grant_id):
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_we = req_valid[g] & ~fifo_full. fifo_wdata = req_data slice g.
  - fifo_we and req_ready are combinational from the registered state.
  - A transfer is fifo_we=1. Each transfer increments beat.
  - fifo_full=1 freezes beat and keeps the grant. There is no timeout.
  - Burst ends on a transfer with beat==MAX_BURST-1, or on a cycle with req_valid[g]=0 (no transfer that cycle).
  - On burst end: last_grant <= g, go to IDLE.
  - There is one bubble cycle between bursts. This is intended and guarantees fairness.
- FLUSH (exactly one cycle):
  - fifo_clr=1, fifo_we=0, req_ready=0.
  - Next state IDLE.
  - flush_done is registered: high in the cycle after FLUSH.
- fifo_wdata: when not in BURST, drive the slice at grant_id. Don't-care, but stable.
- Width rules:
  - beat is $clog2(MAX_BURST+1) bits.
  - The round-robin index wraps modulo N_REQ; non-power-of-two N_REQ must wrap correctly (N_REQ-1 → 0).
- No word is written while fifo_full=1. The fifo also gates internally; the arbiter must not rely on that.

Decomposition:
- Package fifo_arb_pkg:
  - state_t enum {IDLE, BURST, FLUSH}.
  - Function rr_next(valid, last) returning the index.
  - localparam helpers for ID_W and BEAT_W.
- One sub-module, rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, last index.
  - Outputs: grant index, any_valid.
  - Reusable by future read-side schedulers.

Test Plan (N_REQ=4, WORD_SIZE=8, MAX_BURST=4, fifo instantiated behind the arbiter):
1. After rst, only req 0 valid with data 0x10,0x11,... continuously → grant 0 one cycle later; 4 writes 0x10–0x13; 1 IDLE cycle; regrant 0; fifo holds words in order.
2. All four req_valid held high, data = 0xA0+i → grants 0,1,2,3,0 in order; 4 writes each; exactly one idle cycle between bursts; req_ready never high for a non-granted requester.
3. Req 1 granted, fifo_full forced high for 3 cycles after beat 1 → fifo_we=0 and req_ready=0 during the stall; beat frozen; exactly 4 writes total; no duplicate or lost word.
4. flush_req pulsed during the 2nd beat of a burst → burst completes all 4 writes; IDLE; FLUSH with fifo_clr=1 for one cycle; flush_done pulse the next cycle; fifo empty=1 afterwards; pending requests are granted only after the flush.
5. Req 2 drops valid after 2 beats while req 3 is valid → burst ends with 2 writes; the next grant goes to 3, not 2.
6. rst asserted mid-burst (beat 2) → next cycle IDLE, busy=0, fifo_we=0; first grant after release goes to req 0 when all are valid.
